// File: rtl/fwd_hazard_ctrl_pkg.sv
// Shared constants and types for the decode-stage forwarding / hazard control slice.
package fwd_hazard_ctrl_pkg;

  localparam logic [3:0] RNONE_DEF = 4'hF;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RET  = 1'b1
  } hz_state_e;

  // Width of the ret down-counter; never narrower than one bit.
  function automatic int unsigned rc_width(input int unsigned n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fwd_hazard_ctrl_if.sv
// Decode/pipeline-control signal bundle for fwd_hazard_ctrl.
interface fwd_hazard_ctrl_if #(
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned REG_W   = 4,
  parameter int unsigned NUM_SRC = 2,
  parameter int unsigned CNT_W   = 32
);
  logic [NUM_SRC*REG_W-1:0]  d_src_i;
  logic [NUM_SRC*DATA_W-1:0] d_rval_i;
  logic [REG_W-1:0]          e_dstE_i;
  logic [DATA_W-1:0]         e_valE_i;
  logic [REG_W-1:0]          E_dstM_i;
  logic                      E_is_load_i;
  logic [REG_W-1:0]          M_dstM_i;
  logic [DATA_W-1:0]         m_valM_i;
  logic [REG_W-1:0]          M_dstE_i;
  logic [DATA_W-1:0]         M_valE_i;
  logic [REG_W-1:0]          W_dstM_i;
  logic [DATA_W-1:0]         W_valM_i;
  logic [REG_W-1:0]          W_dstE_i;
  logic [DATA_W-1:0]         W_valE_i;
  logic                      D_is_ret_i;
  logic                      e_mispred_i;
  logic [NUM_SRC*DATA_W-1:0] fwd_val_o;
  logic                      F_stall_o;
  logic                      D_stall_o;
  logic                      D_bubble_o;
  logic                      E_bubble_o;
  logic [CNT_W-1:0]          stall_cnt_o;
  logic [CNT_W-1:0]          bubble_cnt_o;

  modport master (
    output d_src_i, d_rval_i, e_dstE_i, e_valE_i, E_dstM_i, E_is_load_i,
           M_dstM_i, m_valM_i, M_dstE_i, M_valE_i, W_dstM_i, W_valM_i,
           W_dstE_i, W_valE_i, D_is_ret_i, e_mispred_i,
    input  fwd_val_o, F_stall_o, D_stall_o, D_bubble_o, E_bubble_o,
           stall_cnt_o, bubble_cnt_o
  );

  modport slave (
    input  d_src_i, d_rval_i, e_dstE_i, e_valE_i, E_dstM_i, E_is_load_i,
           M_dstM_i, m_valM_i, M_dstE_i, M_valE_i, W_dstM_i, W_valM_i,
           W_dstE_i, W_valE_i, D_is_ret_i, e_mispred_i,
    output fwd_val_o, F_stall_o, D_stall_o, D_bubble_o, E_bubble_o,
           stall_cnt_o, bubble_cnt_o
  );

endinterface

// File: rtl/fwd_hazard_ctrl_fwd_sel.sv
// Single-operand forwarding mux: nearest producing stage wins, RNONE never matches.
module fwd_sel_one #(
  parameter int unsigned     DATA_W = 64,
  parameter int unsigned     REG_W  = 4,
  parameter logic [REG_W-1:0] RNONE = '1
) (
  input  logic [REG_W-1:0]  src,
  input  logic [DATA_W-1:0] rval,
  input  logic [REG_W-1:0]  e_dstE,
  input  logic [DATA_W-1:0] e_valE,
  input  logic [REG_W-1:0]  M_dstM,
  input  logic [DATA_W-1:0] m_valM,
  input  logic [REG_W-1:0]  M_dstE,
  input  logic [DATA_W-1:0] M_valE,
  input  logic [REG_W-1:0]  W_dstM,
  input  logic [DATA_W-1:0] W_valM,
  input  logic [REG_W-1:0]  W_dstE,
  input  logic [DATA_W-1:0] W_valE,
  output logic [DATA_W-1:0] val
);

  function automatic logic hit(input logic [REG_W-1:0] s, input logic [REG_W-1:0] d);
    return (s != RNONE) && (d != RNONE) && (d == s);
  endfunction

  always_comb begin
    val = rval;
    if      (hit(src, e_dstE)) val = e_valE;
    else if (hit(src, M_dstM)) val = m_valM;
    else if (hit(src, M_dstE)) val = M_valE;
    else if (hit(src, W_dstM)) val = W_valM;
    else if (hit(src, W_dstE)) val = W_valE;
  end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Y86-64 decode-stage operand forwarding, load-use / ret / mispredict hazard control
// and saturating stall/bubble statistics.
module fwd_hazard_ctrl
  import fwd_hazard_ctrl_pkg::*;
#(
  parameter int unsigned      DATA_W      = 64,
  parameter int unsigned      REG_W       = 4,
  parameter int unsigned      NUM_SRC     = 2,
  parameter logic [REG_W-1:0] RNONE       = REG_W'(RNONE_DEF),
  parameter int unsigned      RET_BUBBLES = 3,
  parameter int unsigned      CNT_W       = 32
) (
  input logic               clk_i,
  input logic               rst_n_i,
  fwd_hazard_ctrl_if.slave  bus
);

  localparam int unsigned RC_W    = rc_width(RET_BUBBLES);
  localparam int unsigned RC_INIT = (RET_BUBBLES > 1) ? RET_BUBBLES - 2 : 0;

  hz_state_e        state, state_nxt;
  logic [RC_W-1:0]  rc, rc_nxt;
  logic             load_use;
  logic             f_stall, d_stall, d_bubble, e_bubble;
  logic [CNT_W-1:0] stall_cnt, bubble_cnt;
  logic [DATA_W-1:0] fwd_val [NUM_SRC];

  for (genvar k = 0; k < NUM_SRC; k++) begin : g_fwd
    fwd_sel_one #(
      .DATA_W (DATA_W),
      .REG_W  (REG_W),
      .RNONE  (RNONE)
    ) u_sel (
      .src    (bus.d_src_i[k*REG_W +: REG_W]),
      .rval   (bus.d_rval_i[k*DATA_W +: DATA_W]),
      .e_dstE (bus.e_dstE_i),
      .e_valE (bus.e_valE_i),
      .M_dstM (bus.M_dstM_i),
      .m_valM (bus.m_valM_i),
      .M_dstE (bus.M_dstE_i),
      .M_valE (bus.M_valE_i),
      .W_dstM (bus.W_dstM_i),
      .W_valM (bus.W_valM_i),
      .W_dstE (bus.W_dstE_i),
      .W_valE (bus.W_valE_i),
      .val    (fwd_val[k])
    );
  end

  always_comb begin
    for (int unsigned k = 0; k < NUM_SRC; k++)
      bus.fwd_val_o[k*DATA_W +: DATA_W] = fwd_val[k];
  end

  // E_dstM != RNONE already excludes RNONE source slots from matching.
  always_comb begin
    load_use = 1'b0;
    if (bus.E_is_load_i && (bus.E_dstM_i != RNONE)) begin
      for (int unsigned k = 0; k < NUM_SRC; k++)
        if (bus.d_src_i[k*REG_W +: REG_W] == bus.E_dstM_i) load_use = 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    rc_nxt    = rc;
    f_stall   = 1'b0;
    d_stall   = 1'b0;
    d_bubble  = 1'b0;
    e_bubble  = 1'b0;
    if (bus.e_mispred_i) begin
      d_bubble  = 1'b1;
      e_bubble  = 1'b1;
      state_nxt = ST_IDLE;
      rc_nxt    = '0;
    end else if (load_use) begin
      f_stall  = 1'b1;
      d_stall  = 1'b1;
      e_bubble = 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.D_is_ret_i) begin
            f_stall  = 1'b1;
            d_bubble = 1'b1;
            if (RET_BUBBLES > 1) begin
              state_nxt = ST_RET;
              rc_nxt    = RC_W'(RC_INIT);
            end
          end
        end
        ST_RET: begin
          f_stall  = 1'b1;
          d_bubble = 1'b1;
          if (rc == '0) state_nxt = ST_IDLE;
          else          rc_nxt    = rc - RC_W'(1);
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
    // Control outputs are forced quiet for the whole reset window, not just at the edge.
    if (!rst_n_i) begin
      f_stall  = 1'b0;
      d_stall  = 1'b0;
      d_bubble = 1'b0;
      e_bubble = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state      <= ST_IDLE;
      rc         <= '0;
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      state <= state_nxt;
      rc    <= rc_nxt;
      if (d_stall && (stall_cnt != '1))   stall_cnt  <= stall_cnt + CNT_W'(1);
      if (d_bubble && (bubble_cnt != '1)) bubble_cnt <= bubble_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    bus.F_stall_o    = f_stall;
    bus.D_stall_o    = d_stall;
    bus.D_bubble_o   = d_bubble;
    bus.E_bubble_o   = e_bubble;
    bus.stall_cnt_o  = stall_cnt;
    bus.bubble_cnt_o = bubble_cnt;
  end

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed scoreboard bench for fwd_hazard_ctrl (DATA_W=64, NUM_SRC=2, RET_BUBBLES=3).
module tb_fwd_hazard_ctrl;

  localparam logic [63:0] RV0 = 64'h1111_0000_0000_0001;
  localparam logic [63:0] RV1 = 64'h2222_0000_0000_0002;
  localparam logic [3:0]  RN  = 4'hF;

  logic clk;
  logic rst_n;

  fwd_hazard_ctrl_if #(.DATA_W(64), .REG_W(4), .NUM_SRC(2), .CNT_W(32)) bus ();

  fwd_hazard_ctrl #(
    .DATA_W(64), .REG_W(4), .NUM_SRC(2), .RNONE(4'hF), .RET_BUBBLES(3), .CNT_W(32)
  ) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    int          sel;
    logic [63:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic want(input string tag, input int sel, input logic [63:0] v);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = v;
    sb.push_back(e);
  endtask

  // ctl = {F_stall, D_stall, D_bubble, E_bubble}
  task automatic want_ctl(input string tag, input logic [3:0] c,
                          input int unsigned sc, input int unsigned bc);
    want({tag, "_ctl"}, 2, 64'(c));
    want({tag, "_scnt"}, 3, 64'(sc));
    want({tag, "_bcnt"}, 4, 64'(bc));
  endtask

  task automatic drain();
    exp_t        e;
    logic [63:0] obs;
    @(negedge clk);
    while (sb.size() != 0) begin
      e = sb.pop_front();
      case (e.sel)
        0:       obs = bus.fwd_val_o[63:0];
        1:       obs = bus.fwd_val_o[127:64];
        2:       obs = {60'd0, bus.F_stall_o, bus.D_stall_o, bus.D_bubble_o, bus.E_bubble_o};
        3:       obs = 64'(bus.stall_cnt_o);
        default: obs = 64'(bus.bubble_cnt_o);
      endcase
      n_chk++;
      assert (obs === e.exp) else begin
        n_fail++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.d_src_i     = {RN, RN};
    bus.d_rval_i    = {RV1, RV0};
    bus.e_dstE_i    = RN;  bus.e_valE_i = '0;
    bus.E_dstM_i    = RN;  bus.E_is_load_i = 1'b0;
    bus.M_dstM_i    = RN;  bus.m_valM_i = '0;
    bus.M_dstE_i    = RN;  bus.M_valE_i = '0;
    bus.W_dstM_i    = RN;  bus.W_valM_i = '0;
    bus.W_dstE_i    = RN;  bus.W_valE_i = '0;
    bus.D_is_ret_i  = 1'b0;
    bus.e_mispred_i = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    idle();
    #3;
    // reset: ret request is ignored while reset is held
    bus.D_is_ret_i = 1'b1;
    want_ctl("rst", 4'b0000, 0, 0);
    drain();
    bus.D_is_ret_i = 1'b0;
    #2 rst_n = 1'b1;
    next();

    // forwarding: e_dstE beats M_dstE, RNONE source reads register file
    bus.d_src_i = {4'h3, RN};
    bus.e_dstE_i = 4'h3; bus.e_valE_i = 64'h11;
    bus.M_dstE_i = 4'h3; bus.M_valE_i = 64'h22;
    want("fwd1_s1", 1, 64'h11);
    want("fwd1_s0", 0, RV0);
    want_ctl("fwd1", 4'b0000, 0, 0);
    drain(); next();

    bus.e_dstE_i = RN;
    want("fwd1b_s1", 1, 64'h22);
    drain(); next();

    idle();
    bus.d_src_i = {RN, 4'h2};
    bus.W_dstE_i = 4'h2; bus.W_valE_i = 64'hAA;
    bus.W_dstM_i = 4'h2; bus.W_valM_i = 64'hBB;
    want("fwd2_s0", 0, 64'hBB);
    drain(); next();

    bus.M_dstM_i = 4'h2; bus.m_valM_i = 64'hCC;
    bus.M_dstE_i = 4'h2; bus.M_valE_i = 64'hDD;
    want("fwd2b_s0", 0, 64'hCC);
    drain(); next();

    idle();
    bus.d_src_i = {RN, 4'h2};
    bus.W_valE_i = 64'hAA; bus.W_valM_i = 64'hBB;
    want("fwd2c_s0", 0, RV0);
    want("fwd2c_s1", 1, RV1);
    drain(); next();

    // RNONE source against RNONE destinations must not forward
    idle();
    bus.e_valE_i = 64'h77; bus.W_valE_i = 64'h88;
    want("fwd_rn_s0", 0, RV0);
    drain(); next();

    // load-use on slot 0
    idle();
    bus.E_is_load_i = 1'b1; bus.E_dstM_i = 4'h5;
    bus.d_src_i = {RN, 4'h5};
    want_ctl("lu", 4'b1101, 0, 0);
    drain(); next();

    idle();
    want_ctl("lu_after", 4'b0000, 1, 0);
    drain(); next();

    bus.E_is_load_i = 1'b1; bus.E_dstM_i = RN;
    want_ctl("lu_rnone", 4'b0000, 1, 0);
    drain(); next();

    idle();
    bus.E_dstM_i = 4'h5; bus.d_src_i = {4'h5, RN};
    want_ctl("lu_noload", 4'b0000, 1, 0);
    drain(); next();

    // ret: three bubble cycles
    idle();
    bus.D_is_ret_i = 1'b1;
    want_ctl("ret1", 4'b1010, 1, 0);
    drain(); next();
    bus.D_is_ret_i = 1'b0;
    want_ctl("ret2", 4'b1010, 1, 1);
    drain(); next();
    want_ctl("ret3", 4'b1010, 1, 2);
    drain(); next();
    want_ctl("ret_done", 4'b0000, 1, 3);
    drain(); next();

    // mispredict aborts a ret sequence
    bus.D_is_ret_i = 1'b1;
    want_ctl("mp_ret1", 4'b1010, 1, 3);
    drain(); next();
    bus.D_is_ret_i = 1'b0; bus.e_mispred_i = 1'b1;
    want_ctl("mp_hit", 4'b0011, 1, 4);
    drain(); next();
    bus.e_mispred_i = 1'b0;
    want_ctl("mp_idle", 4'b0000, 1, 5);
    drain(); next();

    // load-use inside a ret sequence holds the sequence
    bus.D_is_ret_i = 1'b1;
    want_ctl("lr_ret1", 4'b1010, 1, 5);
    drain(); next();
    bus.D_is_ret_i = 1'b0;
    bus.E_is_load_i = 1'b1; bus.E_dstM_i = 4'h5; bus.d_src_i = {4'h5, RN};
    want_ctl("lr_lu", 4'b1101, 1, 6);
    drain(); next();
    idle();
    want_ctl("lr_ret2", 4'b1010, 2, 6);
    drain(); next();
    want_ctl("lr_ret3", 4'b1010, 2, 7);
    drain(); next();
    want_ctl("lr_done", 4'b0000, 2, 8);
    drain(); next();

    // reset in the middle of a ret sequence
    bus.D_is_ret_i = 1'b1;
    want_ctl("rr_ret1", 4'b1010, 2, 8);
    drain(); next();
    bus.D_is_ret_i = 1'b0;
    rst_n = 1'b0;
    bus.d_src_i = {RN, 4'h7};
    bus.e_dstE_i = 4'h7; bus.e_valE_i = 64'h77;
    want("rr_fwd_s0", 0, 64'h77);
    want_ctl("rr_in_rst", 4'b0000, 0, 0);
    drain();
    #2 rst_n = 1'b1;
    next();
    idle();
    want_ctl("rr_release", 4'b0000, 0, 0);
    drain(); next();
    want_ctl("rr_release2", 4'b0000, 0, 0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
